// File: rtl/iot_feeder.sv
// iot_feeder: 4-deep 128-bit record FIFO serialised MSB-first as a gapless byte stream.
module iot_feeder (
  input  logic         clk,
  input  logic         rst,
  input  logic         rec_valid,
  input  logic [127:0] rec_data,
  output logic         rec_ready,
  input  logic [2:0]   cfg_fn,
  input  logic         busy,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic [2:0]   fn_sel,
  output logic [15:0]  rec_sent
);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [127:0] mem_q [4];
  logic [127:0] mem_d [4];
  logic [1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [127:0] shift_q, shift_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]   fn_sel_q, fn_sel_d;
  logic [15:0]  rec_sent_q, rec_sent_d;
  logic         push, pop, empty;

  assign rec_ready = ~cnt_q[2];
  assign in_en     = state_q == SEND;
  assign iot_in    = in_en ? shift_q[127:120] : 8'h00;
  assign fn_sel    = fn_sel_q;
  assign rec_sent  = rec_sent_q;

  always_comb begin
    empty      = cnt_q == 3'd0;
    push       = rec_valid & rec_ready;
    pop        = 1'b0;
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    fn_sel_d   = fn_sel_q;
    rec_sent_d = rec_sent_q;
    case (state_q)
      IDLE: begin
        pop      = ~empty & ~busy;
        state_d  = pop ? SEND : IDLE;
        fn_sel_d = pop ? cfg_fn : fn_sel_q;
      end
      SEND: begin
        shift_d    = shift_q << 8;
        byte_cnt_d = byte_cnt_q - 4'd1;
        if (byte_cnt_q == 4'd0) begin
          rec_sent_d = rec_sent_q + 16'd1;
          pop        = ~empty & ~busy;
          state_d    = empty ? IDLE : (busy ? HOLD : SEND);
        end
      end
      HOLD: begin
        pop     = ~empty & ~busy;
        state_d = pop ? SEND : (empty ? IDLE : HOLD);
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d    = mem_q[rd_ptr_q];
      byte_cnt_d = 4'd15;
    end
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = rec_data;
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      fn_sel_q   <= '0;
      rec_sent_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      fn_sel_q   <= fn_sel_d;
      rec_sent_q <= rec_sent_d;
    end
  end
endmodule

// File: doc/iot_feeder.md
IOT_FEEDER -- requirements
Module: iot_feeder

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 rec_valid  input  1  upstream offers a 128-bit sensor record.
REQ-004 rec_data  input  128  record payload; bits [127:120] are the most significant byte.
REQ-005 rec_ready  output  1  feeder can accept a record this cycle.
REQ-006 cfg_fn  input  3  requested function code for the processing stage.
REQ-007 busy  input  1  processing stage is stalled; do not start a new record.
REQ-008 in_en  output  1  byte strobe to the processing stage.
REQ-009 iot_in  output  8  byte to the processing stage.
REQ-010 fn_sel  output  3  function code to the processing stage.
REQ-011 rec_sent  output  16  count of records fully transmitted since reset.

Function
REQ-012 The block SHALL hold a 4-entry x 128-bit FIFO with 3-bit occupancy count.
REQ-013 rec_ready SHALL equal (occupancy < 4), combinationally from registered state only.
REQ-014 A push SHALL occur on an edge where rec_valid=1 and rec_ready=1.
  - There is no bypass.
  - When the FIFO is full, rec_ready=0 even if a pop occurs on the same edge.
REQ-015 Push and pop on the same edge SHALL leave occupancy unchanged and keep record order.
REQ-016 The FSM SHALL have three states: IDLE, SEND, HOLD.
REQ-017 IDLE -> SEND: on an edge where the FIFO is non-empty and busy=0.
  - That edge pops the head into a 128-bit shift register.
  - byte_cnt SHALL be set to 15.
  - fn_sel SHALL be latched from cfg_fn.
REQ-018 In SEND, in_en=1 and iot_in=shift[127:120] every cycle.
  - Each edge shifts left by 8 and decrements byte_cnt.
REQ-019 A record's 16 bytes SHALL be presented on 16 consecutive cycles with no gap, regardless of busy.
REQ-020 On the SEND edge with byte_cnt=0, rec_sent SHALL increment (wrapping at 16 bits). Then:
  - FIFO non-empty and busy=0: pop the next record, reload byte_cnt=15, stay in SEND; in_en stays continuously high.
  - FIFO non-empty and busy=1: go to HOLD.
  - FIFO empty: go to IDLE.
REQ-021 HOLD -> SEND: on the first edge with busy=0, with a pop as in REQ-017, except fn_sel is not re-latched.
  - HOLD -> IDLE is not permitted while the FIFO is non-empty.
REQ-022 in_en SHALL be 0 in IDLE and HOLD.
  - iot_in SHALL be 8'h00 whenever in_en=0.
REQ-023 fn_sel SHALL change only on the IDLE->SEND transition.
  - cfg_fn changes in any other state are ignored.
REQ-024 Latency: a record pushed into an empty FIFO at edge E0 (state IDLE, busy=0) is popped at edge E1.
  - Its first byte appears with in_en=1 in the cycle after E1.
  - Its last byte appears in the cycle after E16.
REQ-025 Throughput: with the FIFO kept non-empty and busy=0, the block SHALL deliver one byte per cycle indefinitely.

Reset
REQ-026 On rst=1 the block SHALL, asynchronously:
  - set state=IDLE;
  - empty the FIFO (pointers 0, occupancy 0);
  - clear the shift register, byte_cnt=0, rec_sent=0, fn_sel=3'b000;
  - drive in_en=0, iot_in=8'h00, rec_ready=1.
REQ-027 Reset asserted mid-record SHALL discard the partial record and all queued records.
  - No further bytes are emitted until a new push after reset release.

Verification
REQ-028 Single record: after reset, cfg_fn=3'b001, push 128'h000102...0F.
  - in_en high for exactly 16 cycles; iot_in = 00,01,...,0F in order.
  - fn_sel=001; rec_sent=1.
REQ-029 Back-to-back: push 8 records continuously.
  - in_en high for exactly 128 consecutive cycles.
  - rec_ready drops to 0 while occupancy reaches 4.
  - rec_sent=8 at the end.
REQ-030 Busy at a boundary: raise busy during byte 7 of record A while record B is queued.
  - A completes all 16 bytes.
  - in_en=0 while busy=1.
  - B starts the cycle after the first busy=0 edge.
REQ-031 Full plus simultaneous: fill the FIFO to 4 and hold rec_valid=1.
  - No push occurs while full.
  - On the pop edge occupancy becomes 3; the next edge pushes.
  - No record is lost or duplicated (scoreboard over 20 records).
REQ-032 Mid-record reset: pulse rst during byte 9 with 2 records queued.
  - in_en=0 and rec_sent=0 immediately.
  - After release, output stays idle until a new push.
REQ-033 fn_sel stability: change cfg_fn from 001 to 011 mid-stream.
  - fn_sel stays 001 until the stream drains to IDLE.
  - The next record is sent with fn_sel=011.
